// File: rtl/pulp_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: parameter defaults,
// FSM state encoding and the rotating-priority search helper.
package pulp_rr_arbiter_pkg;

  localparam int unsigned N_REQ_DEFAULT    = 32'd4;
  localparam int unsigned MAX_HOLD_DEFAULT = 32'd16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit scanning upward from ptr, wrapping at n (n <= 16).
  function automatic int unsigned rr_pick(input int unsigned ptr,
                                          input logic [15:0] req,
                                          input int unsigned n);
    int unsigned win;
    int unsigned cand;
    logic        found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 32'd0; k < 32'd16; k++) begin
      cand = ptr + k;
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((k < n) && !found && req[cand[3:0]]) begin
        found = 1'b1;
        win   = cand;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder; an all-zero input encodes to index 0.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 32'd4
) (
  input  logic [ONEHOT_WIDTH-1:0]         onehot,
  output logic [$clog2(ONEHOT_WIDTH)-1:0] bin
);

  localparam int unsigned BIN_WIDTH = $clog2(ONEHOT_WIDTH);

  // OR together the indices of all set bits.
  always_comb begin
    bin = {BIN_WIDTH{1'b0}};
    for (int unsigned i = 32'd0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) begin
        bin = bin | BIN_WIDTH'(i);
      end else begin
        bin = bin;
      end
    end
  end

endmodule

// File: rtl/pulp_rr_arbiter.sv
// Round-robin arbiter with a two-state grant FSM, optional hold limit with
// timeout pulse, and a mandatory idle cycle between consecutive grants.
module pulp_rr_arbiter
  import pulp_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     done_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned IDX_W        = $clog2(N_REQ);
  localparam int unsigned HOLD_W       = (MAX_HOLD == 32'd0) ? 32'd1 : $clog2(MAX_HOLD + 32'd1);
  localparam logic        HOLD_LIMITED = (MAX_HOLD != 32'd0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 32'd1);

  arb_state_e        state_r, state_next_s;
  logic [IDX_W-1:0]  ptr_r, ptr_next_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_next_s;
  logic [N_REQ-1:0]  gnt_r, gnt_next_s;
  logic              timeout_r, timeout_next_s;
  logic [IDX_W-1:0]  winner_s;
  logic              owner_req_s;
  logic              hold_limit_s;
  logic              release_s;

  assign winner_s     = IDX_W'(rr_pick(32'(ptr_r), 16'(req_i), N_REQ));
  assign owner_req_s  = |(req_i & gnt_r);
  assign hold_limit_s = HOLD_LIMITED && (hold_cnt_r == HOLD_LAST);
  assign release_s    = done_i || !owner_req_s || hold_limit_s;

  // Next-state, pointer, hold counter and registered-output computation.
  always_comb begin
    state_next_s    = state_r;
    ptr_next_s      = ptr_r;
    hold_cnt_next_s = hold_cnt_r;
    gnt_next_s      = gnt_r;
    timeout_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_i) begin
          state_next_s    = GRANT;
          gnt_next_s      = N_REQ'(1'b1) << winner_s;
          ptr_next_s      = (winner_s == IDX_LAST) ? {IDX_W{1'b0}} : winner_s + IDX_W'(1'b1);
          hold_cnt_next_s = {HOLD_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_next_s    = IDLE;
          gnt_next_s      = {N_REQ{1'b0}};
          hold_cnt_next_s = {HOLD_W{1'b0}};
          // Timeout only when the hold limit is the sole release cause.
          timeout_next_s  = hold_limit_s && !done_i && owner_req_s;
        end else begin
          hold_cnt_next_s = HOLD_LIMITED ? hold_cnt_r + HOLD_W'(1'b1) : hold_cnt_r;
        end
      end
      default: begin
        state_next_s    = IDLE;
        gnt_next_s      = {N_REQ{1'b0}};
        hold_cnt_next_s = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      gnt_r      <= {N_REQ{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ptr_r      <= ptr_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      gnt_r      <= gnt_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  assign gnt_o     = gnt_r;
  assign busy_o    = |gnt_r;
  assign timeout_o = timeout_r;

  onehot_to_bin #(
    .ONEHOT_WIDTH(N_REQ)
  ) u_gnt_idx (
    .onehot(gnt_r),
    .bin   (gnt_idx_o)
  );

endmodule

// File: tb/tb_pulp_rr_arbiter.sv
// Directed bench for pulp_rr_arbiter: an owner/length-based model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_pulp_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = 4'b0000;
  logic       done_i = 1'b0;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       busy_o;
  logic       timeout_o;

  always #5 clk = ~clk;

  pulp_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
    .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Model state: current owner (-1 = none), rotation start, cycles owned so far.
  int m_owner = -1;
  int m_ptr = 0;
  int m_len = 0;
  bit m_timeout = 1'b0;
  bit m_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  string      lit_name = "";
  logic [3:0] lit_gnt = 4'b0000;
  logic       lit_to = 1'b0;
  int         lit_ptr = -1;
  bit         lit_req = 1'b0;
  bit         lit_ack = 1'b0;

  function automatic int pick(int ptr, logic [3:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] owner_gnt(int o);
    return (o < 0) ? 4'b0000 : 4'(1 << o);
  endfunction

  function automatic logic [7:0] pack(logic [3:0] g, logic to);
    int ix;
    ix = 0;
    for (int i = 0; i < 4; i++) if (g[i]) ix = i;
    return {to, |g, 2'(ix), g};
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_owner <= -1; m_ptr <= 0; m_len <= 0; m_timeout <= 1'b0;
    end else if (m_owner < 0) begin
      m_timeout <= 1'b0;
      if (req_i != 4'b0000) begin
        m_owner <= pick(m_ptr, req_i);
        m_ptr   <= (pick(m_ptr, req_i) + 1) % N;
        m_len   <= 1;
      end
    end else if (done_i || !req_i[m_owner] || (MH != 0 && m_len == MH)) begin
      m_owner   <= -1;
      m_len     <= 0;
      m_timeout <= (m_len == MH) && !done_i && req_i[m_owner];
    end else begin
      m_len     <= m_len + 1;
      m_timeout <= 1'b0;
    end
    m_valid <= 1'b1;
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want_v);
    vectors++;
    if (got !== want_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want_v, $time);
    end
  endtask

  // Compare process: model every cycle, literal expectations when posted.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("cycle", {24'd0, timeout_o, busy_o, gnt_idx_o, gnt_o},
            {24'd0, pack(owner_gnt(m_owner), m_timeout)});
        if (lit_req != lit_ack) begin
          chk(lit_name, {24'd0, timeout_o, busy_o, gnt_idx_o, gnt_o}, {24'd0, pack(lit_gnt, lit_to)});
          chk({lit_name, "_model"}, {24'd0, pack(owner_gnt(m_owner), m_timeout)}, {24'd0, pack(lit_gnt, lit_to)});
          if (lit_ptr >= 0) chk({lit_name, "_ptr"}, m_ptr, lit_ptr);
          lit_ack = lit_req;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(string nm, logic [3:0] g, logic to, int p);
    lit_name = nm;
    lit_gnt  = g;
    lit_to   = to;
    lit_ptr  = p;
    lit_req  = ~lit_req;
  endtask

  bit [4:0] tab [12] = '{5'b0110_0, 5'b0110_0, 5'b0110_1, 5'b1001_0, 5'b1001_0, 5'b1001_0,
                         5'b0001_0, 5'b1111_1, 5'b1111_0, 5'b1110_0, 5'b0000_0, 5'b0101_0};

  initial begin
    tick(); tick();
    want("reset", 4'b0000, 1'b0, 0);
    rst_i = 1'b0;
    tick();

    req_i = 4'b1010; tick();
    want("first_grant", 4'b0010, 1'b0, 2);
    req_i = 4'b0000; tick();
    want("first_drop", 4'b0000, 1'b0, 2);
    tick();

    rst_i = 1'b1; tick();
    rst_i = 1'b0; req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      want("rr_order", 4'(1 << (g % 4)), 1'b0, (g + 1) % 4);
      tick(); done_i = 1'b1;
      tick(); done_i = 1'b0;
      want("rr_idle", 4'b0000, 1'b0, -1);
    end
    req_i = 4'b0000; tick();

    req_i = 4'b0100; tick();
    want("hold_c1", 4'b0100, 1'b0, 3);
    for (int c = 2; c <= 16; c++) begin
      tick(); want("hold", 4'b0100, 1'b0, -1);
    end
    tick(); want("timeout", 4'b0000, 1'b1, -1);
    tick(); want("regrant", 4'b0100, 1'b0, 3);
    req_i = 4'b0000; tick();
    want("hold_drop", 4'b0000, 1'b0, -1);
    tick();

    req_i = 4'b0001; tick();
    want("lim_c1", 4'b0001, 1'b0, 1);
    repeat (15) tick();
    done_i = 1'b1;
    want("lim_c16", 4'b0001, 1'b0, -1);
    tick(); want("lim_done", 4'b0000, 1'b0, -1);
    done_i = 1'b0; req_i = 4'b0000; tick();

    req_i = 4'b1000; tick();
    want("wrap_c1", 4'b1000, 1'b0, 0);
    tick(); tick();
    req_i = 4'b0001;
    want("wrap_c3", 4'b1000, 1'b0, -1);
    tick(); want("owner_drop", 4'b0000, 1'b0, 0);
    tick(); want("wrap_next", 4'b0001, 1'b0, 1);
    req_i = 4'b0000; tick(); tick();

    req_i = 4'b0010; tick();
    want("pre_rst", 4'b0010, 1'b0, 2);
    repeat (4) tick();
    rst_i = 1'b1; tick();
    want("rst_mid", 4'b0000, 1'b0, 0);
    rst_i = 1'b0; req_i = 4'b1000; tick();
    want("post_rst", 4'b1000, 1'b0, 0);
    done_i = 1'b1; tick();
    done_i = 1'b0; req_i = 4'b1111;
    want("post_rel", 4'b0000, 1'b0, -1);
    tick(); want("post_wrap", 4'b0001, 1'b0, 1);
    req_i = 4'b0000; tick(); tick();

    for (int i = 0; i < 12; i++) begin
      {req_i, done_i} = tab[i];
      tick();
    end
    req_i = 4'b0000; done_i = 1'b0;
    tick(); tick();

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulp_rr_arbiter.md
PULP_RR_ARBITER -- requirements
Module: pulp_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant length in cycles; 0 = unlimited.
REQ-003 Port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 Port req_i, input, N_REQ: per-requester request level; bit k = requester k.
REQ-006 Port done_i, input, 1: current owner releases the resource this cycle.
REQ-007 Port gnt_o, output, N_REQ: registered one-hot grant; all-zero when no owner.
REQ-008 Port gnt_idx_o, output, $clog2(N_REQ): binary index of the set gnt_o bit; 0 when gnt_o is zero.
REQ-009 Port busy_o, output, 1: high exactly when gnt_o is nonzero.
REQ-010 Port timeout_o, output, 1: one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 IDLE with req_i nonzero: winner = first set bit scanning from ptr upward, modulo N_REQ; next cycle state = GRANT, gnt_o = onehot(winner), ptr = (winner+1) mod N_REQ.
REQ-013 Grant latency SHALL be exactly 1 cycle from the IDLE cycle that samples the request to gnt_o high.
REQ-014 IDLE with req_i zero: state, ptr and outputs unchanged.
REQ-015 In GRANT, gnt_o, gnt_idx_o and busy_o SHALL stay constant until release; req_i changes on other bits have no effect.
REQ-016 Release conditions in GRANT: done_i high, owner's req_i bit low, or hold_cnt == MAX_HOLD-1 with MAX_HOLD != 0. On release, next cycle: state = IDLE, gnt_o = 0, hold_cnt = 0.
REQ-017 hold_cnt SHALL count GRANT cycles starting at 0 on the first grant cycle; its width is $clog2(MAX_HOLD+1).
REQ-018 timeout_o SHALL pulse high for 1 cycle, aligned with gnt_o falling, only when the release is caused solely by the hold limit.
REQ-019 Simultaneous done_i or owner-drop with the hold limit SHALL count as a normal release, with timeout_o low.
REQ-020 IDLE SHALL last at least 1 cycle after every release, so no back-to-back grants occur.
REQ-021 ptr SHALL wrap from N_REQ-1 to 0.
REQ-022 done_i in IDLE SHALL be ignored.
REQ-023 gnt_o SHALL never have more than one bit set.

Reset
REQ-024 rst_i high at a clock edge SHALL set state = IDLE, ptr = 0, hold_cnt = 0, gnt_o = 0, gnt_idx_o = 0, busy_o = 0, timeout_o = 0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt_o on that edge with no timeout pulse; the first arbitration after reset starts from index 0.

Structure
REQ-026 Shared package: parameter defaults (N_REQ, MAX_HOLD) and the state encoding constants IDLE = 0, GRANT = 1.
REQ-027 gnt_idx_o SHALL be derived from gnt_o by one instantiated sub-module, onehot_to_bin, with ONEHOT_WIDTH = N_REQ; no other sub-modules.

Verification
REQ-028 Reset, then req_i = 4'b1010 -> after 1 cycle gnt_o = 4'b0010, gnt_idx_o = 1, busy_o = 1; ptr = 2.
REQ-029 req_i = 4'b1111 held, done_i pulsed on each grant's 2nd cycle -> grant order 0, 1, 2, 3, 0 with one IDLE cycle between grants.
REQ-030 MAX_HOLD = 16, req_i = 4'b0100 held, no done_i -> gnt_o = 4'b0100 for exactly 16 cycles, timeout_o = 1 on the cycle gnt_o returns to 0, then a re-grant to 2 after 1 IDLE cycle.
REQ-031 done_i and the hold limit in the same cycle -> release with timeout_o = 0.
REQ-032 Owner drops req_i in its 3rd grant cycle -> gnt_o = 0 next cycle, timeout_o = 0; ptr wrap checked with the owner at index 3 and the next grant at index 0.
REQ-033 rst_i asserted in the 5th GRANT cycle -> all outputs 0 on that edge; req_i = 4'b1000 afterwards -> grant to 3, as arbitration scans upward from ptr = 0.
